// File: rtl/tge_rx_frame_counter.sv
// rtl/tge_rx_frame_counter.sv - 10GbE RX frame delimiter and good/bad/oversize frame statistics
// Define TGE_RX_FRAME_CNT_SAT_EN to make counters saturate instead of wrap.
module tge_rx_frame_counter #(
   parameter int CNT_WIDTH       = 32,
   parameter int LEN_WIDTH       = 16,
   parameter int MAX_FRAME_WORDS = 1024
) (
   input  logic                 user_clk,
   input  logic                 user_rst,
   input  logic                 rx_valid,
   input  logic                 rx_end_of_frame,
   input  logic                 rx_bad_frame,
   input  logic                 clr,
   input  logic                 freeze,
   output logic [CNT_WIDTH-1:0] frame_cnt,
   output logic [CNT_WIDTH-1:0] bad_cnt,
   output logic [CNT_WIDTH-1:0] oversize_cnt,
   output logic [LEN_WIDTH-1:0] last_len,
   output logic                 rx_active
);

   typedef enum logic [1:0] {IDLE, FRAME, DISCARD} state_t;

   localparam logic [LEN_WIDTH-1:0] LEN_ONE = 1;
   localparam logic [LEN_WIDTH-1:0] MAX_LEN = MAX_FRAME_WORDS;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

   state_t               state, state_nxt;
   logic [LEN_WIDTH-1:0] len, len_nxt, eof_len;
   logic                 good_evt, bad_evt, over_evt;

   logic [CNT_WIDTH-1:0] good_int, bad_int, over_int;
   logic [LEN_WIDTH-1:0] last_len_int;

   function automatic logic [CNT_WIDTH-1:0] bump(input logic [CNT_WIDTH-1:0] v);
`ifdef TGE_RX_FRAME_CNT_SAT_EN
      return (&v) ? v : v + CNT_ONE;
`else
      return v + CNT_ONE;
`endif
   endfunction

   always_comb begin
      state_nxt = state;
      len_nxt   = len;
      eof_len   = len + LEN_ONE;
      good_evt  = 1'b0;
      bad_evt   = 1'b0;
      over_evt  = 1'b0;
      case (state)
         IDLE: begin
            if (rx_valid) begin
               if (rx_end_of_frame) begin
                  eof_len  = LEN_ONE;
                  good_evt = !rx_bad_frame;
                  bad_evt  = rx_bad_frame;
               end else begin
                  state_nxt = FRAME;
                  len_nxt   = LEN_ONE;
               end
            end
         end
         FRAME: begin
            if (rx_valid) begin
               if (rx_end_of_frame) begin
                  good_evt  = !rx_bad_frame;
                  bad_evt   = rx_bad_frame;
                  state_nxt = IDLE;
                  len_nxt   = '0;
               end else if (eof_len == MAX_LEN) begin
                  // Word MAX_FRAME_WORDS arrived without EOF: truncate and drop the rest
                  over_evt  = 1'b1;
                  state_nxt = DISCARD;
                  len_nxt   = eof_len;
               end else begin
                  len_nxt = eof_len;
               end
            end
         end
         DISCARD: begin
            if (rx_valid && rx_end_of_frame) begin
               state_nxt = IDLE;
               len_nxt   = '0;
            end
         end
         default: begin
            state_nxt = IDLE;
            len_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge user_clk or posedge user_rst) begin
      if (user_rst) begin
         state <= IDLE;
         len   <= '0;
      end else begin
         state <= state_nxt;
         len   <= len_nxt;
      end
   end

   // Internal counters; clr wins over any event classified in the same cycle
   always_ff @(posedge user_clk or posedge user_rst) begin
      if (user_rst) begin
         good_int     <= '0;
         bad_int      <= '0;
         over_int     <= '0;
         last_len_int <= '0;
      end else if (clr) begin
         good_int     <= '0;
         bad_int      <= '0;
         over_int     <= '0;
         last_len_int <= '0;
      end else begin
         if (good_evt) begin
            good_int     <= bump(good_int);
            last_len_int <= eof_len;
         end
         if (bad_evt)  bad_int  <= bump(bad_int);
         if (over_evt) over_int <= bump(over_int);
      end
   end

   // Output stage holds a coherent snapshot while freeze is high
   always_ff @(posedge user_clk or posedge user_rst) begin
      if (user_rst) begin
         frame_cnt    <= '0;
         bad_cnt      <= '0;
         oversize_cnt <= '0;
         last_len     <= '0;
      end else if (clr) begin
         frame_cnt    <= '0;
         bad_cnt      <= '0;
         oversize_cnt <= '0;
         last_len     <= '0;
      end else if (!freeze) begin
         frame_cnt    <= good_int;
         bad_cnt      <= bad_int;
         oversize_cnt <= over_int;
         last_len     <= last_len_int;
      end
   end

   assign rx_active = (state != IDLE);

endmodule

// File: tb/tb_tge_rx_frame_counter.sv
// tb/tb_tge_rx_frame_counter.sv - directed self-checking bench for tge_rx_frame_counter
module tb_tge_rx_frame_counter;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid, eof, bad, clr, freeze;
   logic [31:0] frame_cnt, bad_cnt, oversize_cnt;
   logic [15:0] last_len;
   logic        rx_active;

   logic        v4, e4, b4, c4, f4;
   logic [3:0]  cnt4, bad4, over4;
   logic [15:0] len4;
   logic        act4;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   tge_rx_frame_counter #(.CNT_WIDTH(32), .LEN_WIDTH(16), .MAX_FRAME_WORDS(16)) dut (
      .user_clk(clk), .user_rst(rst), .rx_valid(valid), .rx_end_of_frame(eof),
      .rx_bad_frame(bad), .clr(clr), .freeze(freeze), .frame_cnt(frame_cnt),
      .bad_cnt(bad_cnt), .oversize_cnt(oversize_cnt), .last_len(last_len),
      .rx_active(rx_active)
   );

   tge_rx_frame_counter #(.CNT_WIDTH(4), .LEN_WIDTH(16), .MAX_FRAME_WORDS(16)) dut4 (
      .user_clk(clk), .user_rst(rst), .rx_valid(v4), .rx_end_of_frame(e4),
      .rx_bad_frame(b4), .clr(c4), .freeze(f4), .frame_cnt(cnt4),
      .bad_cnt(bad4), .oversize_cnt(over4), .last_len(len4),
      .rx_active(act4)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic word(input logic v, input logic e, input logic b);
      valid = v; eof = e; bad = b;
      tick();
   endtask

   task automatic send_frame(input int n, input logic b);
      for (int i = 1; i <= n; i++) word(1'b1, i == n, b);
      valid = 1'b0; eof = 1'b0; bad = 1'b0;
   endtask

   initial begin
      rst = 1'b1; valid = 0; eof = 0; bad = 0; clr = 0; freeze = 0;
      v4 = 0; e4 = 0; b4 = 0; c4 = 0; f4 = 0;
      tick(); tick();
      chk("reset_frame_cnt", frame_cnt, 0);
      chk("reset_bad_cnt", bad_cnt, 0);
      chk("reset_oversize_cnt", oversize_cnt, 0);
      chk("reset_last_len", {16'd0, last_len}, 0);
      chk("reset_rx_active", {31'd0, rx_active}, 0);
      chk("reset_cnt4", {28'd0, cnt4}, 0);
      rst = 1'b0;
      tick();

      // Mixed frames: first good frame checked for rx_active and 2-cycle latency
      word(1'b1, 1'b0, 1'b0);
      chk("active_after_first_word", {31'd0, rx_active}, 1);
      for (int i = 2; i <= 8; i++) word(1'b1, i == 8, 1'b0);
      valid = 0; eof = 0;
      chk("active_after_eof", {31'd0, rx_active}, 0);
      chk("frame_cnt_latency_1cyc", frame_cnt, 0);
      tick();
      chk("frame_cnt_latency_2cyc", frame_cnt, 1);
      send_frame(8, 1'b0);
      send_frame(8, 1'b0);
      send_frame(8, 1'b1);
      tick();
      chk("mixed_frame_cnt", frame_cnt, 3);
      chk("mixed_bad_cnt", bad_cnt, 1);
      chk("mixed_last_len", {16'd0, last_len}, 8);

      // 20-word frame with limit 16
      for (int i = 1; i <= 19; i++) word(1'b1, 1'b0, 1'b0);
      chk("oversize_counted", oversize_cnt, 1);
      chk("oversize_active_in_discard", {31'd0, rx_active}, 1);
      word(1'b1, 1'b1, 1'b0);
      valid = 0; eof = 0;
      chk("oversize_active_falls", {31'd0, rx_active}, 0);
      tick();
      chk("oversize_frame_cnt_same", frame_cnt, 3);
      chk("oversize_bad_cnt_same", bad_cnt, 1);

      // EOF exactly on word 16 is a normal frame
      send_frame(16, 1'b0);
      tick();
      chk("max_len_frame_cnt", frame_cnt, 4);
      chk("max_len_last_len", {16'd0, last_len}, 16);
      chk("max_len_oversize_same", oversize_cnt, 1);

      // Freeze
      freeze = 1'b1;
      tick();
      for (int k = 0; k < 5; k++) send_frame(3, 1'b0);
      tick();
      chk("freeze_hold", frame_cnt, 4);
      chk("freeze_hold_last_len", {16'd0, last_len}, 16);
      freeze = 1'b0;
      tick();
      chk("freeze_release", frame_cnt, 9);
      chk("freeze_release_last_len", {16'd0, last_len}, 3);

      // Clear colliding with a good EOF
      for (int i = 1; i <= 3; i++) word(1'b1, 1'b0, 1'b0);
      clr = 1'b1;
      word(1'b1, 1'b1, 1'b0);
      clr = 1'b0; valid = 0; eof = 0;
      chk("clr_frame_cnt", frame_cnt, 0);
      chk("clr_bad_cnt", bad_cnt, 0);
      chk("clr_oversize_cnt", oversize_cnt, 0);
      chk("clr_last_len", {16'd0, last_len}, 0);
      tick();
      chk("clr_frame_not_counted", frame_cnt, 0);
      send_frame(2, 1'b0);
      tick();
      chk("after_clr_frame_cnt", frame_cnt, 1);
      chk("after_clr_last_len", {16'd0, last_len}, 2);

      // Asynchronous reset in the middle of a frame
      for (int i = 1; i <= 3; i++) word(1'b1, 1'b0, 1'b0);
      valid = 1'b1; eof = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("async_rst_frame_cnt", frame_cnt, 0);
      chk("async_rst_last_len", {16'd0, last_len}, 0);
      chk("async_rst_rx_active", {31'd0, rx_active}, 0);
      #1 rst = 1'b0;
      valid = 1'b0;
      send_frame(5, 1'b0);
      tick();
      chk("post_rst_frame_cnt", frame_cnt, 1);
      chk("post_rst_last_len", {16'd0, last_len}, 5);

      // 17 back-to-back one-word frames into a 4-bit counter
      v4 = 1'b1; e4 = 1'b1;
      for (int k = 0; k < 17; k++) tick();
      v4 = 1'b0; e4 = 1'b0;
      tick();
`ifdef TGE_RX_FRAME_CNT_SAT_EN
      chk("cnt4_saturate", {28'd0, cnt4}, 15);
`else
      chk("cnt4_wrap", {28'd0, cnt4}, 1);
`endif
      chk("cnt4_last_len", {16'd0, len4}, 1);
      chk("cnt4_rx_active", {31'd0, act4}, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tge_rx_frame_counter.md
# tge_rx_frame_counter

Statistics stage directly upstream of the 10GbE RX frame-count software register. Watches the 10GbE core's RX word stream, delimits frames, and classifies each frame as good, bad, or oversize. Drives the 32-bit `frame_cnt` bus that feeds the register's `user_data_in`, plus companion counters. All logic runs in the user clock domain.

## Interface
- `CNT_WIDTH`, 32: width of every event counter; `frame_cnt` drives the 32-bit register input.
- `LEN_WIDTH`, 16: width of the per-frame word-length counter.
- `MAX_FRAME_WORDS`, 1024: a frame reaching this many words without EOF is oversize.

- `user_clk` in 1: the single clock for the whole block.
- `user_rst` in 1: asynchronous, active-high reset.
- `rx_valid` in 1: RX data word valid this cycle.
- `rx_end_of_frame` in 1: last word of frame; qualified by `rx_valid`.
- `rx_bad_frame` in 1: core flags frame bad (CRC/error); sampled only on a valid EOF beat.
- `clr` in 1: synchronous single-cycle clear of all counters, driven from a software control register.
- `freeze` in 1: level; while high, output counters hold their value for coherent multi-register reads.
- `frame_cnt` out CNT_WIDTH: good frames received.
- `bad_cnt` out CNT_WIDTH: frames ended with `rx_bad_frame`.
- `oversize_cnt` out CNT_WIDTH: frames truncated at `MAX_FRAME_WORDS`.
- `last_len` out LEN_WIDTH: word count of the most recent good frame, including the EOF beat.
- `rx_active` out 1: high while the FSM is in FRAME or DISCARD.

## Operation
- FSM states: IDLE, FRAME, DISCARD. Reset state is IDLE.
- **IDLE**
  - `rx_valid` & EOF: one-word frame. Classify it and stay in IDLE.
  - `rx_valid` & !EOF: go to FRAME with `len`=1.
- **FRAME**
  - Each `rx_valid` increments `len`.
  - Valid EOF: classify the frame and go to IDLE.
    - `rx_bad_frame`=1: `bad_cnt`++.
    - `rx_bad_frame`=0: `frame_cnt`++ and `last_len`←`len`+1.
  - `len`+1 = `MAX_FRAME_WORDS` on a non-EOF valid beat: `oversize_cnt`++, go to DISCARD.
  - A valid EOF on exactly word `MAX_FRAME_WORDS` is a normal frame.
- **DISCARD**: ignore all words until a valid EOF, then go to IDLE. The truncated frame adds nothing to the good or bad counts.
- `rx_valid`=0 cycles are gaps: no state change, `len` holds.
- Internal counters wrap from all-ones to 0 (see Configuration).
- **Clear**
  - `clr` zeroes the internal counters, output counters and `last_len` on the next edge.
  - `clr` has priority over an EOF classified in the same cycle; that frame is not counted.
  - `clr` does not change FSM state or `len`.
- **Freeze**
  - While `freeze`=1, the outputs hold their values and the internal counters keep counting.
  - `clr` during freeze still zeroes the outputs.
- **Reset**: all counters, `len`, `last_len` and `rx_active` = 0; FSM = IDLE.
- **Reset mid-frame**: the partial frame is dropped. Words after reset release are treated from IDLE; a non-EOF word starts a new frame.

## Timing
- The internal counter updates on the edge that samples the EOF beat.
- The output counter reflects it one cycle later: 2-cycle latency from EOF beat to `frame_cnt`.
- `rx_active` rises 1 cycle after the first non-EOF word and falls 1 cycle after EOF.
- On `freeze` deassertion, the outputs load the current internal values on the next edge.
- Back-to-back one-word frames, one per cycle, are each counted; there are no dead cycles.
- No backpressure: the block never stalls the core.

## Configuration
- `TGE_RX_FRAME_CNT_SAT_EN`
  - Defined: every counter saturates at all-ones and stays there until `clr` or reset.
  - Undefined: counters wrap modulo 2^CNT_WIDTH.

## Test plan
- **Mixed frames**: three 8-word frames with `rx_bad_frame`=0, then one with `rx_bad_frame`=1 -> `frame_cnt`=3, `bad_cnt`=1, `last_len`=8, each update 2 cycles after its EOF.
- **Length limit** (`MAX_FRAME_WORDS`=16):
  - 20-word frame -> `oversize_cnt`=1, `frame_cnt` unchanged, `rx_active` high until the EOF at word 20.
  - 16-word frame -> `frame_cnt`+1, `last_len`=16.
- **Freeze**: `freeze`=1, then 5 good frames -> `frame_cnt` holds its old value; drop `freeze` -> next cycle `frame_cnt`=old+5.
- **Clear/EOF collision**: `clr` in the same cycle as a good EOF -> all counters 0, that frame not counted. A following frame -> `frame_cnt`=1.
- **Wrap/saturate**: preload near max with `CNT_WIDTH`=4 and send 17 one-word frames back to back -> `frame_cnt`=1 without the macro, 15 with `TGE_RX_FRAME_CNT_SAT_EN`.
- **Reset mid-frame**: assert `user_rst` asynchronously mid-frame -> outputs 0 immediately, FSM IDLE; the remaining words plus EOF count as one frame of the residual length.
